// File: rtl/vector_bitwise_wb_stage_if.sv
// Register-file write port bus for the vector writeback stage.
// The stage drives beats as master; the register file (or a bench) is the slave.
interface vector_bitwise_wb_stage_if #(
  parameter int VLEN = 4096,
  parameter int WB_W = 512
);
  localparam int NBEATS = VLEN / WB_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_addr;
  logic [BEAT_W-1:0] wb_beat;
  logic [WB_W-1:0]   wb_data;

  modport master (
    output wb_valid,
    input  wb_ready,
    output wb_addr,
    output wb_beat,
    output wb_data
  );

  modport slave (
    input  wb_valid,
    output wb_ready,
    input  wb_addr,
    input  wb_beat,
    input  wb_data
  );
endinterface

// File: rtl/vector_bitwise_wb_stage.sv
// Vector bitwise writeback stage.
// Takes one full-VLEN result per operation, merges it element-wise with the
// old destination contents (v0 mask, vl, vta/vma policy) and streams the
// merged register to the register file in WB_W-bit beats under valid/ready.
module vector_bitwise_wb_stage #(
  parameter int VLEN = 4096,
  parameter int ELEN = 32,
  parameter int WB_W = 512,
  localparam int NBYTES = VLEN / 8,
  localparam int VL_W   = $clog2(VLEN / 8) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VLEN-1:0]         alu_result,
  input  logic [VLEN-1:0]         old_vd,
  input  logic [NBYTES-1:0]       v0_mask,
  input  logic                    vm,
  input  logic [VL_W-1:0]         vl,
  input  logic [1:0]              sew,
  input  logic                    vta,
  input  logic                    vma,
  input  logic [4:0]              vd_addr,
  vector_bitwise_wb_stage_if.master wb,
  output logic                    done
);

  localparam int NBEATS = VLEN / WB_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int BIDX_W = VL_W - 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  // Elaboration-time sanity checks on the configuration.
  generate
    if ((VLEN % WB_W) != 0) begin : g_bad_wb_w
      $error("VLEN must be a multiple of WB_W");
    end
    if (ELEN < 8 || ELEN > 64) begin : g_bad_elen
      $error("ELEN must lie between 8 and 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                       state_r;
  state_t                       next_state_s;
  logic [VLEN-1:0]              merged_s;
  logic [NBEATS-1:0][WB_W-1:0]  buf_r;
  logic [4:0]                   wb_addr_r;
  logic [BEAT_W-1:0]            wb_beat_r;
  logic [WB_W-1:0]              wb_data_r;
  logic                         accept_s;
  logic                         last_xfer_s;
  logic                         in_ready_s;
  logic                         wb_valid_s;
  logic                         done_s;

  assign accept_s    = in_valid && in_ready_s;
  assign last_xfer_s = wb_valid_s && wb.wb_ready && (wb_beat_r == LAST_BEAT);

  // Per-byte merge: every byte inherits the decision of the element it belongs to.
  // Element index never exceeds VLMAX, so comparing against raw vl clamps it for free.
  always_comb begin : merge_blk
    logic [BIDX_W-1:0] byte_idx;
    logic [BIDX_W-1:0] elem_idx;
    logic              active;
    logic              enabled;
    byte_idx = '0;
    elem_idx = '0;
    active   = 1'b0;
    enabled  = 1'b0;
    merged_s = '0;
    for (int b = 0; b < NBYTES; b++) begin
      byte_idx = BIDX_W'(b);
      elem_idx = byte_idx >> sew;
      active   = ({1'b0, elem_idx} < vl);
      enabled  = vm || v0_mask[elem_idx];
      if (active && enabled) begin
        merged_s[b*8 +: 8] = alu_result[b*8 +: 8];
      end else if (active ? vma : vta) begin
        merged_s[b*8 +: 8] = 8'hFF;
      end else begin
        merged_s[b*8 +: 8] = old_vd[b*8 +: 8];
      end
    end
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and handshake decode from the current state.
  always_comb begin
    next_state_s = state_r;
    in_ready_s   = 1'b0;
    wb_valid_s   = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          next_state_s = (vl == VL_W'(0)) ? ST_DONE : ST_WRITE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wb_valid_s = 1'b1;
        if (wb.wb_ready && (wb_beat_r == LAST_BEAT)) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        done_s       = 1'b1;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture merged register on accept, advance beat on each transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_r     <= '0;
      wb_addr_r <= 5'd0;
      wb_beat_r <= '0;
      wb_data_r <= '0;
    end else begin
      if (accept_s) begin
        buf_r     <= merged_s;
        wb_addr_r <= vd_addr;
        wb_beat_r <= '0;
        wb_data_r <= merged_s[WB_W-1:0];
      end else if (wb_valid_s && wb.wb_ready && !last_xfer_s) begin
        wb_beat_r <= wb_beat_r + BEAT_W'(1);
        wb_data_r <= buf_r[wb_beat_r + BEAT_W'(1)];
      end else if (done_s) begin
        wb_beat_r <= '0;
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign done        = done_s;
  assign wb.wb_valid = wb_valid_s;
  assign wb.wb_addr  = wb_addr_r;
  assign wb.wb_beat  = wb_beat_r;
  assign wb.wb_data  = wb_data_r;

endmodule
